// File: rtl/rf_pkg.sv
// Shared sizing and port-index constants for the register-file writeback arbiter.
package rf_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 2;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam int PORT_ALU = 0;
    localparam int PORT_MEM = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with one-hot grant; rr_last remembers the last winner.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic rr_last;

    // On a conflict the port that did not win last time takes the grant.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (req[PORT_ALU] && req[PORT_MEM]) begin
                if (rr_last) gnt[PORT_ALU] = 1'b1;
                else         gnt[PORT_MEM] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     rr_last <= 1'b1;
        else if (|gnt) rr_last <= gnt[PORT_MEM];
    end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port owner: round-robin writeback grant plus per-register pending-write scoreboard.
// Define RF_WB_FORWARD_EN to add same-cycle forwarding outputs that also clear the matching busy.
module rf_writeback_arbiter #(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int CNT_W    = rf_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              mark_ready,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy
`ifdef RF_WB_FORWARD_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);
    import rf_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [1:0]          gnt;
    wb_t                 sel;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                mark_fire;
    logic                commit_on_mark;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[PORT_ALU];
    assign req1_ready = gnt[PORT_MEM];

    always_comb begin
        sel = '0;
        if (gnt[PORT_MEM])      sel = '{addr: req1_addr, data: req1_data};
        else if (gnt[PORT_ALU]) sel = '{addr: req0_addr, data: req0_data};
    end

    // r0 writes are consumed but never reach the register file.
    assign rf_we    = (|gnt) && (sel.addr != ZERO_ADDR);
    assign rf_waddr = sel.addr;
    assign rf_wdata = sel.data;

    // A saturated counter can still take a mark if a commit frees a slot this cycle.
    assign commit_on_mark = rf_we && (rf_waddr == mark_addr);
    assign mark_ready     = !reset && ((mark_addr == ZERO_ADDR) ||
                                       (cnt[mark_addr] != CNT_MAX) || commit_on_mark);
    assign mark_fire      = mark_valid && mark_ready && (mark_addr != ZERO_ADDR);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = mark_fire && (mark_addr == ADDR_W'(r));
            dec_vec[r] = rf_we && (rf_waddr == ADDR_W'(r));
        end
    end

    // Mark and commit on the same register cancel; commits never underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    // Last outstanding write landing now: consumer can take the data directly.
    assign fwd1_hit  = rf_we && (rf_waddr == rs1_addr) && (cnt[rs1_addr] == CNT_ONE);
    assign fwd2_hit  = rf_we && (rf_waddr == rs2_addr) && (cnt[rs2_addr] == CNT_ONE);
    assign fwd1_data = rf_wdata;
    assign fwd2_data = rf_wdata;
    assign rs1_busy  = !reset && (rs1_addr != ZERO_ADDR) && (cnt[rs1_addr] != '0) && !fwd1_hit;
    assign rs2_busy  = !reset && (rs2_addr != ZERO_ADDR) && (cnt[rs2_addr] != '0) && !fwd2_hit;
`else
    assign rs1_busy  = !reset && (rs1_addr != ZERO_ADDR) && (cnt[rs1_addr] != '0);
    assign rs2_busy  = !reset && (rs2_addr != ZERO_ADDR) && (cnt[rs2_addr] != '0);
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: grants go through a scoreboard queue, status signals are checked inline.
module tb_rf_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        mark_valid;
    logic [4:0]  mark_addr;
    logic        mark_ready;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
`ifdef RF_WB_FORWARD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rf_writeback_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .mark_valid (mark_valid),
        .mark_addr  (mark_addr),
        .mark_ready (mark_ready),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
`ifdef RF_WB_FORWARD_EN
        ,
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic push(input logic port, input logic we, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port; e.we = we; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: every grant must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_ready || req1_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant_port", {31'd0, req1_ready}, {31'd0, e.port});
                    chk("rf_we",      {31'd0, rf_we},     {31'd0, e.we});
                    chk("rf_waddr",   {27'd0, rf_waddr},  {27'd0, e.addr});
                    chk("rf_wdata",   rf_wdata,           e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mark_valid = 1'b0; mark_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rs1_addr = '0; rs2_addr = '0;

        // Reset state, with traffic presented that must be ignored
        nxt();
        mark_valid = 1'b1; mark_addr = 5'd3;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        at_neg();
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_mark_ready", {31'd0, mark_ready}, 32'd0);
        chk("rst_rf_we",      {31'd0, rf_we},      32'd0);
        chk("rst_rs1_busy",   {31'd0, rs1_busy},   32'd0);
        nxt();
        mark_valid = 1'b0; req0_valid = 1'b0;
        reset = 1'b0;

        // Single ALU write, zero latency
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5;
        push(1'b0, 1'b1, 5'd5, 32'hA5);
        at_neg();
        nxt();
        req0_valid = 1'b0;

        // Both ports valid every cycle after reset: 0,1,0,1
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        push(1'b0, 1'b1, 5'd3, 32'h11);
        push(1'b1, 1'b1, 5'd4, 32'h22);
        push(1'b0, 1'b1, 5'd3, 32'h11);
        push(1'b1, 1'b1, 5'd4, 32'h22);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            nxt();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Mark r7, then commit it
        mark_valid = 1'b1; mark_addr = 5'd7;
        at_neg();
        chk("mark7_ready", {31'd0, mark_ready}, 32'd1);
        nxt();
        mark_valid = 1'b0; rs1_addr = 5'd7;
        at_neg();
        chk("r7_busy_marked", {31'd0, rs1_busy}, 32'd1);
        nxt();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        push(1'b0, 1'b1, 5'd7, 32'h77);
        at_neg();
`ifdef RF_WB_FORWARD_EN
        chk("r7_fwd_hit",  {31'd0, fwd1_hit}, 32'd1);
        chk("r7_fwd_data", fwd1_data, 32'h77);
        chk("r7_busy_commit", {31'd0, rs1_busy}, 32'd0);
`else
        chk("r7_busy_commit", {31'd0, rs1_busy}, 32'd1);
`endif
        nxt();
        req0_valid = 1'b0;
        at_neg();
        chk("r7_busy_after", {31'd0, rs1_busy}, 32'd0);
        nxt();

        // Saturate r9 at three pending writes
        mark_valid = 1'b1; mark_addr = 5'd9; rs2_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("mark9_ready", {31'd0, mark_ready}, 32'd1);
            nxt();
        end
        at_neg();
        chk("mark9_full", {31'd0, mark_ready}, 32'd0);
        nxt();
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        push(1'b1, 1'b1, 5'd9, 32'h99);
        at_neg();
        chk("mark9_with_commit", {31'd0, mark_ready}, 32'd1);
        nxt();
        req1_valid = 1'b0;
        at_neg();
        chk("mark9_still_full", {31'd0, mark_ready}, 32'd0);
        chk("r9_busy", {31'd0, rs2_busy}, 32'd1);
        nxt();
        mark_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h90 + i;
            push(1'b0, 1'b1, 5'd9, 32'h90 + i);
            at_neg();
            nxt();
        end
        req0_valid = 1'b0;
        at_neg();
        chk("r9_busy_one_left", {31'd0, rs2_busy}, 32'd1);
        nxt();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h92;
        push(1'b0, 1'b1, 5'd9, 32'h92);
        at_neg();
        nxt();
        req0_valid = 1'b0;
        at_neg();
        chk("r9_drained", {31'd0, rs2_busy}, 32'd0);
        nxt();

        // Register 0: consumed without writing, mark has no effect
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF;
        push(1'b1, 1'b0, 5'd0, 32'hFFFF);
        at_neg();
        nxt();
        req1_valid = 1'b0;
        mark_valid = 1'b1; mark_addr = 5'd0;
        at_neg();
        chk("mark0_ready", {31'd0, mark_ready}, 32'd1);
        nxt();
        mark_valid = 1'b0; rs2_addr = 5'd0;
        at_neg();
        chk("r0_busy", {31'd0, rs2_busy}, 32'd0);
        nxt();

        // Reset mid-traffic drops pending state and rearms the arbiter
        rs1_addr = 5'd2; rs2_addr = 5'd6;
        mark_valid = 1'b1; mark_addr = 5'd2;
        nxt();
        mark_addr = 5'd6;
        nxt();
        mark_valid = 1'b0;
        at_neg();
        chk("r2_busy_pre", {31'd0, rs1_busy}, 32'd1);
        chk("r6_busy_pre", {31'd0, rs2_busy}, 32'd1);
        nxt();
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
        push(1'b0, 1'b1, 5'd12, 32'hC);
        at_neg();
        nxt();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAA;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBB;
        at_neg();
        chk("mid_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("mid_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("mid_rst_rf_we",      {31'd0, rf_we},      32'd0);
        chk("mid_rst_rs1_busy",   {31'd0, rs1_busy},   32'd0);
        chk("mid_rst_rs2_busy",   {31'd0, rs2_busy},   32'd0);
        nxt();
        reset = 1'b0;
        push(1'b0, 1'b1, 5'd10, 32'hAA);
        at_neg();
        chk("post_rst_r2_busy", {31'd0, rs1_busy}, 32'd0);
        chk("post_rst_r6_busy", {31'd0, rs2_busy}, 32'd0);
        nxt();
        req0_valid = 1'b0; req1_valid = 1'b0;
        at_neg();
        nxt();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
